// File: rtl/uart_bus_slave.sv
// Memory-mapped UART bus responder: DATA / COUNT / STATUS registers in a 16-byte window,
// with RX and TX byte FIFOs between the system bus and the serial cores.
module uart_bus_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hc0000000,
  parameter int                    FIFO_DEPTH = 8,
  parameter int                    DATA_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_en,
  input  logic                  i_rnw,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_data_valid,
  output logic                  o_busy,
  input  logic                  i_rx_valid,
  input  logic [DATA_BITS-1:0]  i_rx_data,
  output logic                  o_tx_valid,
  output logic [DATA_BITS-1:0]  o_tx_data,
  input  logic                  i_tx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RESP} state_t;
  state_t state_reg, state_next;

  logic [DATA_BITS-1:0]  rx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  tx_mem [FIFO_DEPTH];
  logic [AW-1:0]         rx_rd_ptr_reg, rx_wr_ptr_reg, tx_rd_ptr_reg, tx_wr_ptr_reg;
  logic [CW-1:0]         rx_cnt_reg, rx_cnt_next, tx_cnt_reg, tx_cnt_next;
  logic                  rxovr_reg, rxovr_next, txdrop_reg, txdrop_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rd_val;

  logic       hit, accept, rx_empty, rx_full, tx_empty, tx_full;
  logic       rx_push, rx_pop, tx_push, tx_pop, tx_push_req, status_wr;
  logic [1:0] offset;
  logic       unused_wdata;

  assign hit    = (i_addr >= BASE_ADDR) && ((i_addr - BASE_ADDR) < ADDR_WIDTH'(16));
  assign offset = i_addr[3:2];
  assign accept = (state_reg == IDLE) && i_en && hit;

  assign rx_empty = (rx_cnt_reg == '0);
  assign rx_full  = (rx_cnt_reg == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_reg == '0);
  assign tx_full  = (tx_cnt_reg == CW'(FIFO_DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign rx_pop      = accept && i_rnw && (offset == 2'd0) && !rx_empty;
  assign rx_push     = i_rx_valid && (!rx_full || rx_pop);
  assign tx_pop      = !tx_empty && i_tx_ready;
  assign tx_push_req = accept && !i_rnw && (offset == 2'd0);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign status_wr   = accept && !i_rnw && (offset == 2'd2);

  assign unused_wdata = ^i_wdata;

  // Set beats a same-cycle write-1-to-clear.
  assign rxovr_next  = (i_rx_valid && rx_full && !rx_pop) ||
                       (rxovr_reg && !(status_wr && i_wdata[2]));
  assign txdrop_next = (tx_push_req && tx_full && !tx_pop) ||
                       (txdrop_reg && !(status_wr && i_wdata[3]));

  always_comb begin
    rx_cnt_next = rx_cnt_reg;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_next = rx_cnt_reg + CW'(1);
      2'b01:   rx_cnt_next = rx_cnt_reg - CW'(1);
      default: rx_cnt_next = rx_cnt_reg;
    endcase
    tx_cnt_next = tx_cnt_reg;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_next = tx_cnt_reg + CW'(1);
      2'b01:   tx_cnt_next = tx_cnt_reg - CW'(1);
      default: tx_cnt_next = tx_cnt_reg;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      2'd0: if (!rx_empty) rd_val[DATA_BITS-1:0] = rx_mem[rx_rd_ptr_reg];
      2'd1: begin
        rd_val[CW-1:0]   = rx_cnt_reg;
        rd_val[8+CW-1:8] = tx_cnt_reg;
      end
      2'd2:    rd_val[3:0] = {txdrop_reg, rxovr_reg, tx_full, rx_empty};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= i_rx_data;
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= i_wdata[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_wr_ptr_reg <= '0;
      rx_cnt_reg    <= '0;
      tx_cnt_reg    <= '0;
      rxovr_reg     <= 1'b0;
      txdrop_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + AW'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + AW'(1);
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + AW'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + AW'(1);
      rx_cnt_reg <= rx_cnt_next;
      tx_cnt_reg <= tx_cnt_next;
      rxovr_reg  <= rxovr_next;
      txdrop_reg <= txdrop_next;
      if (accept) rdata_reg <= i_rnw ? rd_val : '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (state_reg == RESP);
    o_data_valid = (state_reg == RESP);
  end

  assign o_rdata    = rdata_reg;
  assign o_tx_valid = !tx_empty;
  assign o_tx_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr_reg];

endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed bench for uart_bus_slave: register access, FIFO boundaries, miss decode and reset.
module tb_uart_bus_slave;

  localparam logic [31:0] BASE = 32'hc0000000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        i_en = 1'b0, i_rnw = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_data_valid, o_busy;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready = 1'b0;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  int n;

  uart_bus_slave dut (
    .clk(clk), .n_rst(n_rst), .i_en(i_en), .i_rnw(i_rnw), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_data_valid(o_data_valid), .o_busy(o_busy),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata);
    @(negedge clk);
    i_en = 1'b1; i_rnw = rnw; i_addr = addr; i_wdata = wd;
    chk("busy_in_idle", o_busy, 0);
    @(posedge clk); #1 i_en = 1'b0;
    @(negedge clk);
    chk("resp_valid", o_data_valid, 1);
    chk("resp_busy", o_busy, 1);
    rdata = o_rdata;
    $display("access rnw=%0d addr=%h wdata=%h rdata=%h", rnw, addr, wd, rdata);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_valid = 1'b1; i_rx_data = b;
    @(posedge clk); #1 i_rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state and STATUS read timing
    repeat (2) @(negedge clk);
    chk("rst_dv", o_data_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_txv", o_tx_valid, 0);
    chk("rst_txd", o_tx_data, 0);
    n_rst = 1'b1;
    access(1, BASE + 32'h8, 0, rd);
    chk("t1_status", rd, 32'h1);
    @(negedge clk);
    chk("t1_busy_after", o_busy, 0);
    chk("t1_dv_after", o_data_valid, 0);

    // 2: two RX bytes
    rx_byte(8'h41);
    rx_byte(8'h42);
    access(1, BASE + 32'h4, 0, rd);   chk("t2_count", rd, 32'h2);
    access(1, BASE + 32'h0, 0, rd);   chk("t2_pop0", rd, 32'h41);
    access(1, BASE + 32'h3, 0, rd);   chk("t2_pop1", rd, 32'h42);
    access(1, BASE + 32'h0, 0, rd);   chk("t2_empty", rd, 32'h0);

    // 3: RX overrun and W1C
    for (int i = 0; i < 9; i++) rx_byte(8'(i));
    access(1, BASE + 32'h8, 0, rd);   chk("t3_status", rd, 32'h4);
    access(1, BASE + 32'h4, 0, rd);   chk("t3_count", rd, 32'h8);
    access(0, BASE + 32'h8, 32'h4, rd);
    access(1, BASE + 32'h8, 0, rd);   chk("t3_cleared", rd, 32'h0);
    for (int i = 0; i < 8; i++) begin
      access(1, BASE, 0, rd);         chk("t3_drain", rd, 32'(i));
    end

    // 4: TX fill, drop, drain
    i_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) access(0, BASE, 32'h155, rd);
    access(1, BASE + 32'h4, 0, rd);   chk("t4_count", rd, 32'h800);
    access(1, BASE + 32'h8, 0, rd);   chk("t4_status", rd, 32'hB);
    @(negedge clk);
    i_tx_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_tx_valid) begin
        chk("t4_txdata", o_tx_data, 8'h55);
        n++;
      end
      @(negedge clk);
    end
    i_tx_ready = 1'b0;
    chk("t4_txcount", n, 8);
    chk("t4_txv_end", o_tx_valid, 0);
    access(0, BASE + 32'h8, 32'h8, rd);
    access(1, BASE + 32'h8, 0, rd);   chk("t4_cleared", rd, 32'h1);

    // 5: miss, then i_en held through RESP
    @(negedge clk);
    i_en = 1'b1; i_rnw = 1'b0; i_addr = BASE + 32'h1000; i_wdata = 32'h5A;
    @(posedge clk); #1 i_en = 1'b0;
    @(negedge clk);
    chk("t5_miss_dv", o_data_valid, 0);
    chk("t5_miss_busy", o_busy, 0);
    access(1, BASE + 32'h4, 0, rd);   chk("t5_miss_count", rd, 32'h0);
    @(negedge clk);
    i_en = 1'b1; i_rnw = 1'b0; i_addr = BASE; i_wdata = 32'h11;
    @(posedge clk); #1 i_wdata = 32'h22;
    @(negedge clk);
    chk("t5_dv", o_data_valid, 1);
    @(posedge clk); #1 i_en = 1'b0;
    @(negedge clk);
    chk("t5_no_second_dv", o_data_valid, 0);
    access(1, BASE + 32'h4, 0, rd);   chk("t5_count", rd, 32'h100);
    chk("t5_txdata", o_tx_data, 8'h11);
    @(negedge clk); i_tx_ready = 1'b1;
    @(posedge clk); #1 i_tx_ready = 1'b0;
    @(negedge clk);
    chk("t5_txv_end", o_tx_valid, 0);

    // 6: push into full RX in the same cycle as a DATA pop
    for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i));
    @(negedge clk);
    i_en = 1'b1; i_rnw = 1'b1; i_addr = BASE; i_rx_valid = 1'b1; i_rx_data = 8'h18;
    @(posedge clk); #1 begin i_en = 1'b0; i_rx_valid = 1'b0; end
    @(negedge clk);
    chk("t6_dv", o_data_valid, 1);
    chk("t6_rdata", o_rdata, 32'h10);
    access(1, BASE + 32'h4, 0, rd);   chk("t6_count", rd, 32'h8);
    access(1, BASE + 32'h8, 0, rd);   chk("t6_status", rd, 32'h0);
    for (int i = 1; i < 9; i++) begin
      access(1, BASE, 0, rd);         chk("t6_drain", rd, 32'h10 + 32'(i));
    end

    // 7: reset during RESP
    rx_byte(8'h77);
    access(0, BASE, 32'h66, rd);
    @(negedge clk);
    i_en = 1'b1; i_rnw = 1'b1; i_addr = BASE + 32'h8;
    @(posedge clk); #1 i_en = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    chk("t7_dv_rst", o_data_valid, 0);
    chk("t7_busy_rst", o_busy, 0);
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
    chk("t7_dv_after", o_data_valid, 0);
    chk("t7_txv", o_tx_valid, 0);
    access(1, BASE + 32'h4, 0, rd);   chk("t7_count", rd, 32'h0);
    access(1, BASE + 32'h8, 0, rd);   chk("t7_status", rd, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
